// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants.
package core_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT      = 2'd1,
      WAIT_DROP = 2'd2
   } fetch_state_e;

   // Decode substitutes this when no fetched instruction is available.
   localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Small power-of-two FIFO with synchronous clear; clear beats push and pop.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           wdata,
   output logic [WIDTH-1:0]           rdata,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push, do_pop;

   assign do_push = push & ~clear;
   assign do_pop  = pop & ~clear & ~empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            mem_q[wptr_q] <= wdata;
            wptr_q        <= wptr_q + AW'(1);
         end
         if (do_pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   assign rdata = mem_q[rptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // Upstream credit accounting must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
      (push && !pop && !clear) |-> !full);

endmodule

// File: rtl/fetch_buffer.sv
// Instruction fetch: single-outstanding imem requests, {pc,instr} FIFO to decode, flush on redirect.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = core_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_addr,
   output logic            pc_en,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            id_valid,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_instr,
   input  logic            id_ready,
   output logic            err_spurious
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   fetch_state_e      state_q, state_d;
   logic [XLEN-1:0]   out_pc_q;
   logic              err_q;
   logic              push, pop, grant, full, empty;
   logic [CW-1:0]     count, cnt_after;
   logic [2*XLEN-1:0] rdata;

   assign pop       = ~empty & id_ready & ~flush;
   assign push      = (state_q == WAIT) & imem_rvalid & ~flush;
   assign cnt_after = count + CW'(push) - CW'(pop);

   // A new request needs a free slot even after the in-flight response lands.
   always_comb begin
      imem_req = 1'b0;
      if (rst && !flush) begin
         case (state_q)
            IDLE:    imem_req = ~full;
            WAIT:    imem_req = imem_rvalid & (cnt_after < DEPTH_C);
            default: imem_req = 1'b0;
         endcase
      end
   end

   assign grant     = imem_req & imem_gnt;
   assign pc_en     = grant;
   assign imem_addr = pc_addr;

   always_comb begin
      state_d = state_q;
      if (flush) begin
         if (state_q != IDLE) state_d = imem_rvalid ? IDLE : WAIT_DROP;
      end else begin
         case (state_q)
            IDLE:      if (grant) state_d = WAIT;
            WAIT:      if (imem_rvalid) state_d = grant ? WAIT : IDLE;
            WAIT_DROP: if (imem_rvalid) state_d = IDLE;
            default:   state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         out_pc_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) out_pc_q <= pc_addr;
         if (state_q == IDLE && imem_rvalid) err_q <= 1'b1;
      end
   end

   sync_fifo #(
      .WIDTH (2*XLEN),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .clear (flush),
      .wdata ({out_pc_q, imem_rdata}),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign id_valid     = ~empty;
   assign id_pc        = rdata[2*XLEN-1:XLEN];
   assign id_instr     = rdata[XLEN-1:0];
   assign err_spurious = err_q;

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer with a queue-based reference model checked every cycle.
module tb_fetch_buffer;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] pc_addr = '0;
   logic        pc_en;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_ready = 1'b0;
   logic        err_spurious;

   int checks = 0;
   int failures = 0;

   // Reference model: buffered pairs, plus the one fetch that may be in flight.
   logic [63:0] mq[$];
   logic        m_out  = 1'b0;
   logic        m_drop = 1'b0;
   logic [31:0] m_opc  = '0;
   logic        m_err  = 1'b0;

   // Bench-side PC unit / memory bookkeeping.
   logic        pend = 1'b0;
   logic [31:0] pend_addr = '0;
   int          n_grant = 0;
   logic [31:0] dlv_pc[$];
   logic [31:0] dlv_in[$];

   fetch_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .pc_addr      (pc_addr),
      .pc_en        (pc_en),
      .flush        (flush),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .id_valid     (id_valid),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_ready     (id_ready),
      .err_spurious (err_spurious)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return 32'h13 + (a << 8);
   endfunction

   // Credit rule: only one fetch in flight, and buffered + in-flight must stay below DEPTH.
   function automatic logic exp_req();
      int occ;
      if (!rst || flush) return 1'b0;
      if (!m_out) return (mq.size() < DEPTH);
      if (m_drop || !imem_rvalid) return 1'b0;
      occ = mq.size() + 1 - ((mq.size() > 0 && id_ready) ? 1 : 0);
      return (occ < DEPTH);
   endfunction

   always @(negedge clk) begin : cmp
      logic er;
      if (!rst) begin
         mq.delete();
         m_out = 1'b0; m_drop = 1'b0; m_opc = '0; m_err = 1'b0;
      end
      er = exp_req();
      chk1("imem_req", imem_req, er);
      chk1("pc_en", pc_en, er & imem_gnt);
      chk1("id_valid", id_valid, mq.size() > 0);
      chk1("err_spurious", err_spurious, m_err);
      if (mq.size() > 0) begin
         chk32("id_pc", id_pc, mq[0][63:32]);
         chk32("id_instr", id_instr, mq[0][31:0]);
      end
      if (imem_req) chk32("imem_addr", imem_addr, pc_addr);
      if (rst) begin
         if (!m_out && imem_rvalid) m_err = 1'b1;
         if (flush) begin
            mq.delete();
            if (m_out) begin
               if (imem_rvalid) begin m_out = 1'b0; m_drop = 1'b0; end
               else m_drop = 1'b1;
            end
         end else begin
            if (mq.size() > 0 && id_ready) void'(mq.pop_front());
            if (m_out && imem_rvalid) begin
               if (!m_drop) mq.push_back({m_opc, imem_rdata});
               m_out = 1'b0; m_drop = 1'b0;
            end
            if (er && imem_gnt) begin m_out = 1'b1; m_opc = pc_addr; end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input logic fl, input logic g, input logic rv,
                         input logic [31:0] rd, input logic rdy);
      flush = fl; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; id_ready = rdy;
   endtask

   // Memory answers one cycle after each grant; the PC advances on pc_en.
   task automatic cycle_auto(input logic g, input logic rdy);
      logic        gr;
      logic [31:0] ga;
      set_in(1'b0, g, pend, instr_of(pend_addr), rdy);
      #1;
      if (id_valid && id_ready) begin
         dlv_pc.push_back(id_pc);
         dlv_in.push_back(id_instr);
      end
      gr = pc_en;
      ga = imem_addr;
      if (gr) n_grant++;
      step();
      pend = gr;
      pend_addr = ga;
      if (gr) pc_addr = pc_addr + 32'd4;
   endtask

   task automatic clear_log();
      dlv_pc.delete(); dlv_in.delete(); n_grant = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset
      step(); step();
      chk1("rst_id_valid", id_valid, 1'b0);
      chk1("rst_imem_req", imem_req, 1'b0);
      chk1("rst_pc_en", pc_en, 1'b0);
      chk1("rst_err", err_spurious, 1'b0);
      rst = 1'b1;

      // Streaming fetch
      pc_addr = 32'h0; clear_log();
      for (int i = 0; i < 6; i++) cycle_auto(1'b1, 1'b1);
      chk32("stream_grants", n_grant, 32'd6);
      chk32("stream_count", dlv_pc.size(), 32'd4);
      chk32("stream_pc0", dlv_pc[0], 32'h0);
      chk32("stream_pc1", dlv_pc[1], 32'h4);
      chk32("stream_pc2", dlv_pc[2], 32'h8);
      chk32("stream_in0", dlv_in[0], 32'h13);
      chk32("stream_in1", dlv_in[1], 32'h413);
      chk32("stream_in2", dlv_in[2], 32'h813);
      for (int i = 0; i < 3; i++) cycle_auto(1'b0, 1'b1);
      chk1("stream_drained", id_valid, 1'b0);

      // Backpressure
      pc_addr = 32'h0; clear_log();
      for (int i = 0; i < 6; i++) cycle_auto(1'b1, 1'b0);
      chk32("bp_grants", n_grant, 32'd2);
      chk1("bp_req_off", imem_req, 1'b0);
      chk1("bp_pcen_off", pc_en, 1'b0);
      chk1("bp_valid", id_valid, 1'b1);
      chk32("bp_pc_held", id_pc, 32'h0);
      clear_log();
      for (int i = 0; i < 6; i++) cycle_auto(1'b1, 1'b1);
      chk32("bp_resume_grants", n_grant, 32'd5);
      chk32("bp_drain0", dlv_pc[0], 32'h0);
      chk32("bp_drain1", dlv_pc[1], 32'h4);
      chk32("bp_drain2", dlv_pc[2], 32'h8);
      for (int i = 0; i < 3; i++) cycle_auto(1'b0, 1'b1);

      // Flush with a request in flight
      pc_addr = 32'h10; set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
      chk1("fl_grant", pc_en, 1'b1); step();
      pc_addr = 32'h100; set_in(1'b1, 1'b1, 1'b0, 32'h0, 1'b1); #1;
      chk1("fl_req_off", imem_req, 1'b0);
      chk1("fl_pcen_off", pc_en, 1'b0); step();
      set_in(1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1); #1;
      chk1("drop_noreq", imem_req, 1'b0); step();
      set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b1); #1;
      chk1("drop_novalid", id_valid, 1'b0);
      chk1("redir_req", imem_req, 1'b1);
      chk32("redir_addr", imem_addr, 32'h100); step();
      set_in(1'b0, 1'b0, 1'b1, 32'hCAFE0013, 1'b0); step();
      pc_addr = 32'h104; set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
      chk1("redir_valid", id_valid, 1'b1);
      chk32("redir_pc", id_pc, 32'h100);
      chk32("redir_instr", id_instr, 32'hCAFE0013); step();

      // Flush together with rvalid and pop, one entry buffered
      set_in(1'b1, 1'b1, 1'b1, 32'h11111111, 1'b1); #1;
      chk1("co_req_off", imem_req, 1'b0); step();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk1("co_empty", id_valid, 1'b0);
      chk1("co_idle_req", imem_req, 1'b1); step();
      chk1("co_still_empty", id_valid, 1'b0);

      // Spurious response while idle
      set_in(1'b0, 1'b0, 1'b1, 32'h22222222, 1'b1); #1;
      chk1("sp_pre", err_spurious, 1'b0); step();
      set_in(1'b0, 1'b0, 1'b0, 32'h0, 1'b1); #1;
      chk1("sp_set", err_spurious, 1'b1);
      chk1("sp_fifo", id_valid, 1'b0); step(); step();
      chk1("sp_hold", err_spurious, 1'b1);

      // Asynchronous reset in the middle of a cycle
      pc_addr = 32'h300; set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); step();
      set_in(1'b0, 1'b0, 1'b1, 32'h33333333, 1'b0); step();
      set_in(1'b0, 1'b1, 1'b0, 32'h0, 1'b0); #1;
      chk1("pre_rst_req", imem_req, 1'b1);
      chk1("pre_rst_pcen", pc_en, 1'b1);
      chk1("pre_rst_valid", id_valid, 1'b1);
      chk1("pre_rst_err", err_spurious, 1'b1);
      #1 rst = 1'b0;
      #1;
      chk1("arst_valid", id_valid, 1'b0);
      chk1("arst_req", imem_req, 1'b0);
      chk1("arst_pcen", pc_en, 1'b0);
      chk1("arst_err", err_spurious, 1'b0);
      step();
      rst = 1'b1; pend = 1'b0; pc_addr = 32'h200; clear_log();
      for (int i = 0; i < 4; i++) cycle_auto(1'b1, 1'b1);
      chk32("restart_count", dlv_pc.size(), 32'd2);
      chk32("restart_pc0", dlv_pc[0], 32'h200);
      chk32("restart_in0", dlv_in[0], 32'h20013);
      chk32("restart_pc1", dlv_pc[1], 32'h204);
      for (int i = 0; i < 3; i++) cycle_auto(1'b0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
